// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared TMDS definitions used by both the encoder and receiver sides:
//   tmds_symbol_t   10-bit TMDS symbol, bit 0 is the first bit on the wire
//   CTRL_TOKEN_xx   the four control tokens, suffix is {C1,C0}
//   rx_state_t      receiver word-alignment states
// -----------------------------------------------------------------------------
package tmds_pkg;

    typedef logic [9:0] tmds_symbol_t;

    localparam tmds_symbol_t CTRL_TOKEN_00 = 10'b1101010100;
    localparam tmds_symbol_t CTRL_TOKEN_01 = 10'b0010101011;
    localparam tmds_symbol_t CTRL_TOKEN_10 = 10'b0101010100;
    localparam tmds_symbol_t CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } rx_state_t;

endpackage

// File: rtl/tmds_ctrl_detect.sv
// -----------------------------------------------------------------------------
// tmds_ctrl_detect
// Combinational control-token classifier.
//   symbol  in   10-bit TMDS symbol (bit 0 = first bit received)
//   is_tok  out  symbol is one of the four control tokens
//   ctrl    out  {C1,C0} of the token, 00 when is_tok = 0
// -----------------------------------------------------------------------------
module tmds_ctrl_detect
    import tmds_pkg::*;
(
    input  tmds_symbol_t symbol,
    output logic         is_tok,
    output logic [1:0]   ctrl
);

    always_comb begin
        is_tok = 1'b1;
        ctrl   = 2'b00;
        case (symbol)
            CTRL_TOKEN_00: ctrl = 2'b00;
            CTRL_TOKEN_01: ctrl = 2'b01;
            CTRL_TOKEN_10: ctrl = 2'b10;
            CTRL_TOKEN_11: ctrl = 2'b11;
            default:       is_tok = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_deserializer.sv
// -----------------------------------------------------------------------------
// tmds_deserializer
// Recovers aligned 10-bit TMDS symbols from a serial bit stream by locking the
// word boundary onto repeated control tokens.
//   serial_clk  in   bit clock, one serial bit per rising edge
//   rst_n       in   asynchronous active-low reset
//   din         in   serial stream, symbol LSB first
//   word        out  aligned symbol (holds between strobes)
//   word_valid  out  one-cycle strobe, one per 10 bit times while locked
//   ctrl_token  out  strobed word is a control token
//   ctrl        out  {C1,C0} of the strobed token, 00 otherwise
//   locked      out  receiver is in LOCKED
//   lock_lost   out  one-cycle pulse on LOCKED -> HUNT
// -----------------------------------------------------------------------------
module tmds_deserializer
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned UNLOCK_TIMEOUT = 2048
) (
    input  logic       serial_clk,
    input  logic       rst_n,
    input  logic       din,
    output logic [9:0] word,
    output logic       word_valid,
    output logic       ctrl_token,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic       lock_lost
);

    localparam int unsigned      TMO_W       = $clog2(UNLOCK_TIMEOUT + 1);
    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(UNLOCK_TIMEOUT - 1);
    localparam logic [3:0]       PHASE_LAST  = 4'd9;

    tmds_symbol_t     sr;
    logic [3:0]       phase, phase_nxt;
    logic [3:0]       match_cnt, match_nxt;
    logic [TMO_W-1:0] timeout_cnt, timeout_nxt;
    rx_state_t        state, state_nxt;
    logic             is_tok;
    logic [1:0]       det_ctrl;
    logic             boundary;
    logic             strobe_nxt;
    logic             lost_nxt;

    tmds_ctrl_detect u_ctrl_detect (
        .symbol (sr),
        .is_tok (is_tok),
        .ctrl   (det_ctrl)
    );

    assign boundary = (phase == PHASE_LAST);
    assign locked   = (state == LOCKED);

    always_ff @(posedge serial_clk or negedge rst_n) begin
        if (!rst_n) begin
            sr          <= '0;
            phase       <= '0;
            match_cnt   <= '0;
            timeout_cnt <= '0;
            state       <= HUNT;
        end else begin
            sr          <= {din, sr[9:1]};
            phase       <= phase_nxt;
            match_cnt   <= match_nxt;
            timeout_cnt <= timeout_nxt;
            state       <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = (phase == PHASE_LAST) ? '0 : phase + 4'd1;
        match_nxt   = match_cnt;
        timeout_nxt = timeout_cnt;
        strobe_nxt  = 1'b0;
        lost_nxt    = 1'b0;
        case (state)
            HUNT: begin
                // The detected token closes a word, so the next cycle is
                // phase 0 and the boundary recurs every 10 cycles from there.
                phase_nxt = '0;
                if (is_tok) begin
                    state_nxt = VERIFY;
                    match_nxt = 4'd1;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (is_tok) begin
                        match_nxt = match_cnt + 4'd1;
                        if (match_nxt == LOCK_TARGET) begin
                            state_nxt   = LOCKED;
                            timeout_nxt = '0;
                        end
                    end else begin
                        state_nxt = HUNT;
                        match_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (is_tok) begin
                        timeout_nxt = '0;
                        strobe_nxt  = 1'b1;
                    end else if (timeout_cnt == TMO_LAST) begin
                        // The word that exhausts the timeout is not strobed.
                        state_nxt   = HUNT;
                        lost_nxt    = 1'b1;
                        timeout_nxt = '0;
                        match_nxt   = '0;
                    end else begin
                        timeout_nxt = timeout_cnt + TMO_W'(1);
                        strobe_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge serial_clk or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            word_valid <= 1'b0;
            ctrl_token <= 1'b0;
            ctrl       <= 2'b00;
            lock_lost  <= 1'b0;
        end else begin
            word_valid <= strobe_nxt;
            lock_lost  <= lost_nxt;
            if (strobe_nxt) begin
                word       <= sr;
                ctrl_token <= is_tok;
                ctrl       <= det_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_tmds_deserializer.sv
`timescale 1ns/1ps
module tb_tmds_deserializer;

    localparam int         LC     = 4;
    localparam int         UT     = 16;
    localparam logic [9:0] DATA_W = 10'b0111110000;

    localparam int M_HUNT   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    typedef struct {
        int         tag;
        logic [9:0] w;
        logic       tok;
        logic [1:0] c;
    } exp_strobe_t;

    logic       serial_clk = 1'b0;
    logic       rst_n      = 1'b0;
    logic       din        = 1'b0;
    logic [9:0] word;
    logic       word_valid;
    logic       ctrl_token;
    logic [1:0] ctrl;
    logic       locked;
    logic       lock_lost;

    tmds_deserializer #(
        .LOCK_COUNT     (LC),
        .UNLOCK_TIMEOUT (UT)
    ) dut (
        .serial_clk (serial_clk),
        .rst_n      (rst_n),
        .din        (din),
        .word       (word),
        .word_valid (word_valid),
        .ctrl_token (ctrl_token),
        .ctrl       (ctrl),
        .locked     (locked),
        .lock_lost  (lock_lost)
    );

    always #5 serial_clk = ~serial_clk;

    int unsigned n_cmp     = 0;
    int unsigned n_bad     = 0;
    int          edge_cnt  = 0;
    int          lost_seen = 0;
    logic        mon_en    = 1'b0;

    // Scoreboard: expectations are tagged with the edge_cnt value at which
    // the monitor must see them.
    exp_strobe_t sq[$];
    int          lost_q[$];
    bit          exp_locked[int];

    // Reference model: last 10 bits received plus alignment bookkeeping
    // expressed as bit positions of expected word boundaries.
    logic hist[$];
    int   m_mode;
    int   m_cnt;
    int   m_miss;
    int   m_bd;

    always @(posedge serial_clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [9:0] tok_of(input logic [1:0] c);
        case (c)
            2'd0:    return 10'b1101010100;
            2'd1:    return 10'b0010101011;
            2'd2:    return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset(input int now);
        hist.delete();
        for (int unsigned i = 0; i < 10; i++) hist.push_back(1'b0);
        m_mode = M_HUNT;
        m_cnt  = 0;
        m_miss = 0;
        m_bd   = 0;
        sq.delete();
        lost_q.delete();
        exp_locked.delete();
        exp_locked[now]     = 1'b0;
        exp_locked[now + 1] = 1'b0;
    endfunction

    // Bit with position 'tag' has just been put on the wire.
    function automatic void model_bit(input logic b, input int tag);
        logic [9:0] w;
        int         ti;
        hist.push_back(b);
        void'(hist.pop_front());
        for (int unsigned i = 0; i < 10; i++) w[i] = hist[i];
        ti = -1;
        for (int unsigned i = 0; i < 4; i++)
            if (w == tok_of(2'(i))) ti = int'(i);
        case (m_mode)
            M_HUNT: begin
                if (ti >= 0) begin
                    m_mode = M_VERIFY;
                    m_cnt  = 1;
                    m_bd   = tag + 10;
                end
            end
            M_VERIFY: begin
                if (tag == m_bd) begin
                    m_bd += 10;
                    if (ti >= 0) begin
                        m_cnt++;
                        if (m_cnt == LC) begin
                            m_mode = M_LOCKED;
                            m_miss = 0;
                        end
                    end else begin
                        m_mode = M_HUNT;
                    end
                end
            end
            default: begin
                if (tag == m_bd) begin
                    m_bd += 10;
                    if (ti >= 0) begin
                        m_miss = 0;
                        sq.push_back('{tag + 2, w, 1'b1, 2'(ti)});
                    end else begin
                        m_miss++;
                        if (m_miss == UT) begin
                            m_mode = M_HUNT;
                            lost_q.push_back(tag + 2);
                        end else begin
                            sq.push_back('{tag + 2, w, 1'b0, 2'b00});
                        end
                    end
                end
            end
        endcase
        exp_locked[tag + 2] = (m_mode == M_LOCKED);
    endfunction

    task automatic send_bit(input logic b);
        @(negedge serial_clk);
        din = b;
        model_bit(b, edge_cnt);
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int unsigned i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    // 3 ns low pulse between clock edges; outputs must clear immediately.
    task automatic apply_reset();
        @(posedge serial_clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_word", 32'(word), 32'd0);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_ctrl_token", 32'(ctrl_token), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_lock_lost", 32'(lock_lost), 32'd0);
        #2 rst_n = 1'b1;
        model_reset(edge_cnt);
        mon_en = 1'b1;
    endtask

    // Monitor
    always @(negedge serial_clk) begin
        if (mon_en && rst_n) begin
            while (sq.size() > 0 && sq[0].tag < edge_cnt) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_strobe: got none expected word %b due at edge %0d", sq[0].w, sq[0].tag);
                void'(sq.pop_front());
            end
            if (word_valid === 1'b1) begin
                if (sq.size() > 0 && sq[0].tag == edge_cnt) begin
                    check("strobe_word", 32'(word), 32'(sq[0].w));
                    check("strobe_ctrl_token", 32'(ctrl_token), 32'(sq[0].tok));
                    check("strobe_ctrl", 32'(ctrl), 32'(sq[0].c));
                    void'(sq.pop_front());
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: got word %b expected no strobe at edge %0d", word, edge_cnt);
                end
            end
            while (lost_q.size() > 0 && lost_q[0] < edge_cnt) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_lock_lost: got none expected pulse at edge %0d", lost_q[0]);
                void'(lost_q.pop_front());
            end
            if (lock_lost === 1'b1) begin
                lost_seen++;
                if (lost_q.size() > 0 && lost_q[0] == edge_cnt) begin
                    n_cmp++;
                    void'(lost_q.pop_front());
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_lock_lost: got 1 expected 0 at edge %0d", edge_cnt);
                end
            end
            if (exp_locked.exists(edge_cnt)) begin
                check("locked", 32'(locked), 32'(exp_locked[edge_cnt]));
                exp_locked.delete(edge_cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lost_before;

        // Reset then idle
        apply_reset();
        repeat (200) send_bit(1'b0);
        check("idle_locked", 32'(locked), 32'd0);
        check("idle_word", 32'(word), 32'd0);
        check("idle_word_valid", 32'(word_valid), 32'd0);
        check("idle_ctrl_token", 32'(ctrl_token), 32'd0);
        check("idle_ctrl", 32'(ctrl), 32'd0);
        check("idle_lock_lost", 32'(lock_lost), 32'd0);

        // Lock from a 3-bit offset
        repeat (3) send_bit(1'($urandom));
        repeat (8) send_word(tok_of(2'd0));
        check("offset_locked", 32'(locked), 32'd1);

        // Control decode while locked
        send_word(tok_of(2'd1));
        send_word(tok_of(2'd2));
        send_word(tok_of(2'd3));
        send_word(DATA_W);
        repeat (2) send_word(tok_of(2'd0));
        check("decode_locked", 32'(locked), 32'd1);

        // Loss of lock after a one-bit slip, then relock
        lost_before = lost_seen;
        send_bit(1'b1);
        repeat (40) send_word(tok_of(2'd0));
        check("slip_lost_count", 32'(lost_seen - lost_before), 32'd1);
        check("slip_relocked", 32'(locked), 32'd1);

        // Reset mid-lock; relock needs a full token sequence
        apply_reset();
        repeat (3) send_word(tok_of(2'd0));
        check("rst_partial_locked", 32'(locked), 32'd0);
        repeat (3) send_word(tok_of(2'd0));
        check("rst_relocked", 32'(locked), 32'd1);

        // False lock rejection
        apply_reset();
        repeat (20) send_bit(1'b0);
        send_word(tok_of(2'd3));
        repeat (6) send_word(DATA_W);
        check("false_lock_locked", 32'(locked), 32'd0);

        // Randomized mix
        for (int unsigned seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 4))
                0: repeat ($urandom_range(1, 8)) send_word(tok_of(2'($urandom_range(0, 3))));
                1: repeat ($urandom_range(1, 4)) send_word(10'($urandom));
                2: repeat ($urandom_range(1, 3)) send_bit(1'($urandom));
                3: repeat ($urandom_range(3, 6)) send_word(tok_of(2'd0));
                default: begin
                    if ($urandom_range(0, 5) == 0) apply_reset();
                    else send_word(DATA_W);
                end
            endcase
        end
        repeat (20) send_word(DATA_W);

        @(negedge serial_clk);
        @(negedge serial_clk);
        #1 mon_en = 1'b0;
        check("pending_strobes", 32'(sq.size()), 32'd0);
        check("pending_lock_lost", 32'(lost_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
